// File: rtl/masked_and_hpc1_pipe.sv
// HPC1 masked AND gadget: order-D Boolean shares, W independent lanes.
// Two-stage pipeline: share refresh of b, then randomised cross-products.
module masked_and_hpc1_pipe #(
   parameter int D = 3,
   parameter int W = 1
) (
   input  logic                  clock_0,
   input  logic                  reset_0,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [(D+1)*W-1:0]    a_shares,
   input  logic [(D+1)*W-1:0]    b_shares,
   input  logic [D*(D+1)/2*W-1:0] rand_ref,
   input  logic [D*(D+1)/2*W-1:0] rand_mul,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [(D+1)*W-1:0]    c_shares
);

   localparam int NS = D + 1;
   localparam int NR = D * (D + 1) / 2;

   // Lexicographic index of the unordered share pair {i,j}, i != j.
   function automatic int pidx(input int i, input int j);
      int lo, hi, p;
      lo = (i < j) ? i : j;
      hi = (i < j) ? j : i;
      p = 0;
      for (int k = 0; k < lo; k++) p += D - k;
      return p + (hi - lo - 1);
   endfunction

   logic                 adv;
   logic                 v1, v2;
   logic [NS*W-1:0]      a_reg, v_reg, v_next;
   logic [NR*W-1:0]      r_reg;
   logic [NS*NS*W-1:0]   z_reg, z_next;

   // Handshake: an input transfers on a clock edge when in_valid && in_ready;
   // an output transfers when out_valid && out_ready. The whole pipe advances
   // together, so in_ready is simply "the output slot is free or draining".
   assign adv       = !v2 || out_ready;
   assign in_ready  = adv;
   assign out_valid = v2;

   always_comb begin
      v_next = '0;
      for (int i = 0; i < NS; i++) begin
         v_next[i*W +: W] = b_shares[i*W +: W];
         for (int j = 0; j < NS; j++) begin
            if (j != i) v_next[i*W +: W] = v_next[i*W +: W] ^ rand_ref[pidx(i, j)*W +: W];
         end
      end
   end

   // z_ij and z_ji share one random so the pair cancels in the unmasked sum.
   always_comb begin
      z_next = '0;
      for (int i = 0; i < NS; i++) begin
         for (int j = 0; j < NS; j++) begin
            z_next[(i*NS+j)*W +: W] = a_reg[i*W +: W] & v_reg[j*W +: W];
            if (i != j)
               z_next[(i*NS+j)*W +: W] = z_next[(i*NS+j)*W +: W] ^ r_reg[pidx(i, j)*W +: W];
         end
      end
   end

   always_comb begin
      c_shares = '0;
      for (int i = 0; i < NS; i++) begin
         for (int j = 0; j < NS; j++) begin
            c_shares[i*W +: W] = c_shares[i*W +: W] ^ z_reg[(i*NS+j)*W +: W];
         end
      end
   end

   always_ff @(posedge clock_0) begin
      if (reset_0) begin
         v1    <= 1'b0;
         v2    <= 1'b0;
         a_reg <= '0;
         v_reg <= '0;
         r_reg <= '0;
         z_reg <= '0;
      end else if (adv) begin
         v1    <= in_valid;
         a_reg <= a_shares;
         v_reg <= v_next;
         r_reg <= rand_mul;
         v2    <= v1;
         z_reg <= z_next;
      end
   end

endmodule

// File: tb/tb_masked_and_hpc1_pipe.sv
// Bench for masked_and_hpc1_pipe: three configurations (D=3/W=1, D=1/W=8,
// D=2/W=4), directed share vectors plus scoreboarded unmasked results.
module tb_masked_and_hpc1_pipe;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // D=3, W=1
   logic        iv3, ir3, ov3, or3;
   logic [3:0]  a3, b3, c3;
   logic [5:0]  rr3, rm3;
   // D=1, W=8
   logic        iv1, ir1, ov1, or1;
   logic [15:0] a1, b1, c1;
   logic [7:0]  rr1, rm1;
   // D=2, W=4
   logic        iv2, ir2, ov2, or2;
   logic [11:0] a2, b2, c2, rr2, rm2;

   masked_and_hpc1_pipe #(.D(3), .W(1)) dut3 (
      .clock_0(clk), .reset_0(rst), .in_valid(iv3), .in_ready(ir3),
      .a_shares(a3), .b_shares(b3), .rand_ref(rr3), .rand_mul(rm3),
      .out_valid(ov3), .out_ready(or3), .c_shares(c3));

   masked_and_hpc1_pipe #(.D(1), .W(8)) dut1 (
      .clock_0(clk), .reset_0(rst), .in_valid(iv1), .in_ready(ir1),
      .a_shares(a1), .b_shares(b1), .rand_ref(rr1), .rand_mul(rm1),
      .out_valid(ov1), .out_ready(or1), .c_shares(c1));

   masked_and_hpc1_pipe #(.D(2), .W(4)) dut2 (
      .clock_0(clk), .reset_0(rst), .in_valid(iv2), .in_ready(ir2),
      .a_shares(a2), .b_shares(b2), .rand_ref(rr2), .rand_mul(rm2),
      .out_valid(ov2), .out_ready(or2), .c_shares(c2));

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Scoreboards: expected unmasked a&b pushed on accept, popped on retire.
   logic [0:0] exp_q3[$];
   logic [7:0] exp_q1[$];
   logic [3:0] exp_q2[$];
   int retired3 = 0;

   always @(negedge clk) begin
      if (rst) begin
         exp_q3.delete();
         exp_q1.delete();
         exp_q2.delete();
      end else begin
         if (ov3 && or3) begin
            retired3++;
            if (exp_q3.size() == 0) check_eq("d3_unexpected", 1, 0);
            else check_eq("d3_result", ^c3, exp_q3.pop_front());
         end
         if (iv3 && ir3) exp_q3.push_back((^a3) & (^b3));

         if (ov1 && or1) begin
            if (exp_q1.size() == 0) check_eq("d1_unexpected", 1, 0);
            else check_eq("d1_result", c1[7:0] ^ c1[15:8], exp_q1.pop_front());
         end
         if (iv1 && ir1) exp_q1.push_back((a1[7:0] ^ a1[15:8]) & (b1[7:0] ^ b1[15:8]));

         if (ov2 && or2) begin
            if (exp_q2.size() == 0) check_eq("d2_unexpected", 1, 0);
            else check_eq("d2_result", c2[3:0] ^ c2[7:4] ^ c2[11:8], exp_q2.pop_front());
         end
         if (iv2 && ir2)
            exp_q2.push_back((a2[3:0] ^ a2[7:4] ^ a2[11:8]) & (b2[3:0] ^ b2[7:4] ^ b2[11:8]));
      end
   end

   task automatic drive3(input logic v, input logic [3:0] a, input logic [3:0] b,
                         input logic [5:0] rr, input logic [5:0] rm);
      iv3 = v; a3 = a; b3 = b; rr3 = rr; rm3 = rm;
   endtask

   task automatic rand3();
      drive3(1'b1, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
             6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)));
   endtask

   logic [3:0] held_c;
   int         base;
   logic [7:0] m, mb;

   initial begin
      rst = 1'b1;
      drive3(1'b0, 4'h0, 4'h0, 6'h0, 6'h0);
      or3 = 1'b1;
      iv1 = 1'b0; a1 = '0; b1 = '0; rr1 = '0; rm1 = '0; or1 = 1'b1;
      iv2 = 1'b0; a2 = '0; b2 = '0; rr2 = '0; rm2 = '0; or2 = 1'b1;
      tick(); tick();
      check_eq("rst_out_valid3", ov3, 0);
      check_eq("rst_c3", c3, 0);
      check_eq("rst_out_valid1", ov1, 0);
      check_eq("rst_c1", c1, 0);
      check_eq("rst_c2", c2, 0);
      rst = 1'b0;
      tick();
      check_eq("rst_in_ready3", ir3, 1);

      // Single op a=(1,0,0,0) b=(1,0,0,0), zero randomness: latency and shares.
      drive3(1'b1, 4'b0001, 4'b0001, 6'h0, 6'h0);
      tick();
      drive3(1'b0, 4'h0, 4'h0, 6'h0, 6'h0);
      check_eq("lat_plus1_valid", ov3, 0);
      tick();
      check_eq("lat_plus2_valid", ov3, 1);
      check_eq("single_shares", c3, 4'b0001);
      tick();
      check_eq("single_drained", ov3, 0);

      // Hand-computed shares: a=(1,0,1,0) b=(0,1,0,0), rand_mul pair (0,1) set.
      drive3(1'b1, 4'b0101, 4'b0010, 6'h00, 6'b000001);
      tick();
      // a=(0,1,1,0), refresh pair (1,2), mul pair (1,3).
      drive3(1'b1, 4'b0110, 4'b0000, 6'b001000, 6'b010000);
      tick();
      drive3(1'b0, 4'h0, 4'h0, 6'h0, 6'h0);
      check_eq("hand_shares_0", c3, 4'b0110);
      tick();
      check_eq("hand_shares_1", c3, 4'b1010);
      tick();

      // Bubble pattern 1,0,1.
      rand3(); tick();
      iv3 = 1'b0; tick();
      check_eq("bubble_out_0", ov3, 1);
      rand3(); tick();
      check_eq("bubble_out_1", ov3, 0);
      iv3 = 1'b0; tick();
      check_eq("bubble_out_2", ov3, 1);
      tick();
      check_eq("bubble_drained", ov3, 0);

      // Stall with a full pipe: everything holds for 5 cycles.
      or3 = 1'b0;
      rand3(); tick();
      rand3(); tick();
      held_c = c3;
      for (int k = 0; k < 5; k++) begin
         rand3();
         #1;
         check_eq("stall_in_ready", ir3, 0);
         check_eq("stall_out_valid", ov3, 1);
         check_eq("stall_c_hold", c3, held_c);
         tick();
      end
      or3 = 1'b1;
      iv3 = 1'b0;
      tick(); tick(); tick();
      check_eq("stall_drained", ov3, 0);

      // Reset with two ops in flight discards both.
      rand3(); tick();
      rand3(); tick();
      iv3 = 1'b0;
      rst = 1'b1;
      tick();
      check_eq("midrst_out_valid", ov3, 0);
      check_eq("midrst_c", c3, 0);
      check_eq("midrst_in_ready", ir3, 1);
      rst = 1'b0;
      for (int k = 0; k < 3; k++) begin
         tick();
         check_eq("midrst_no_stale", ov3, 0);
      end

      // Back-to-back random traffic, one op per cycle.
      base = retired3;
      for (int k = 0; k < 10000; k++) begin
         rand3();
         #1;
         check_eq("b2b_in_ready", ir3, 1);
         if (k >= 2) check_eq("b2b_out_valid", ov3, 1);
         tick();
      end
      iv3 = 1'b0;
      tick(); tick(); tick();
      check_eq("b2b_retired", retired3 - base, 10000);
      check_eq("b2b_queue_empty", exp_q3.size(), 0);

      // D=1, W=8: unmasked a=F0, b=3C under random masks gives 30.
      for (int k = 0; k < 20; k++) begin
         m  = 8'($urandom_range(0, 255));
         mb = 8'($urandom_range(0, 255));
         iv1 = 1'b1;
         a1 = {m, 8'hF0 ^ m};
         b1 = {mb, 8'h3C ^ mb};
         rr1 = 8'($urandom_range(0, 255));
         rm1 = 8'($urandom_range(0, 255));
         tick();
         if (k >= 1) check_eq("d1_c30", c1[7:0] ^ c1[15:8], 8'h30);
      end
      iv1 = 1'b0;
      tick(); tick(); tick();
      check_eq("d1_queue_empty", exp_q1.size(), 0);

      // D=2, W=4: random sweep with random valid and backpressure.
      for (int k = 0; k < 2000; k++) begin
         iv2 = 1'($urandom_range(0, 1));
         or2 = ($urandom_range(0, 3) != 0);
         a2  = 12'($urandom_range(0, 4095));
         b2  = 12'($urandom_range(0, 4095));
         rr2 = 12'($urandom_range(0, 4095));
         rm2 = 12'($urandom_range(0, 4095));
         tick();
      end
      iv2 = 1'b0;
      or2 = 1'b1;
      tick(); tick(); tick();
      check_eq("d2_queue_empty", exp_q2.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
